// File: rtl/vga_axil_regfile.sv
// vga_axil_regfile: AXI4-Lite responder for the VGA control register bank.
// Independent write and read state machines. One register index is read-only
// and returns the live status word. The RW registers are exported flattened.

package vga_axil_pkg;
   typedef logic [31:0] axil_addr_t;
   typedef logic [31:0] axil_data_t;
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axil_resp_e;
endpackage

module vga_axil_regfile
   import vga_axil_pkg::*;
#(
   parameter int unsigned REG_NUM    = 8,
   parameter int unsigned STATUS_IDX = REG_NUM - 1,
   parameter logic [31:0] RESET_VAL  = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  axil_addr_t              awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  axil_data_t              wdata,
   input  logic                    wvalid,
   output logic                    wready,
   output axil_resp_e              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  axil_addr_t              araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output axil_data_t              rdata,
   output axil_resp_e              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   input  logic [31:0]             status_i,
   output logic [REG_NUM*32-1:0]   regs_o
);

   localparam int unsigned IDX_W      = $clog2(REG_NUM);
   localparam axil_addr_t  ADDR_LIMIT = axil_addr_t'(REG_NUM * 4);
   localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(STATUS_IDX);

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
   typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_e;

   // Word-aligned and inside the register window.
   function automatic logic addr_valid(input axil_addr_t a);
      return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input axil_addr_t a);
      return a[2 +: IDX_W];
   endfunction

   logic [31:0]      regs_q [REG_NUM];
   wstate_e          wstate_q;
   rstate_e          rstate_q;
   logic             bvalid_q;
   axil_resp_e       bresp_q;
   logic             arready_q;
   logic             rvalid_q;
   axil_resp_e       rresp_q;
   axil_data_t       rdata_q;

   logic             aw_hs_s;
   logic             wr_ok_s;
   logic             ar_hs_s;
   logic             rd_ok_s;
   logic [IDX_W-1:0] rd_idx_s;
   axil_data_t       rd_data_s;

   // Write handshake: address and data must arrive together, only when idle.
   always_comb begin
      aw_hs_s = 1'b0;
      wr_ok_s = addr_valid(awaddr) && (addr_idx(awaddr) != STAT_IDX);
      if (wstate_q == W_IDLE) begin
         aw_hs_s = awvalid && wvalid;
      end else begin
         aw_hs_s = 1'b0;
      end
   end

   // Read decode: status word at its index, zero for illegal addresses.
   always_comb begin
      rd_idx_s  = addr_idx(araddr);
      rd_ok_s   = addr_valid(araddr);
      ar_hs_s   = arvalid && arready_q;
      rd_data_s = 32'h0000_0000;
      if (!rd_ok_s) begin
         rd_data_s = 32'h0000_0000;
      end else if (rd_idx_s == STAT_IDX) begin
         rd_data_s = status_i;
      end else begin
         rd_data_s = regs_q[rd_idx_s];
      end
   end

   // Write response FSM: latch response on handshake, hold until accepted.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wstate_q <= W_IDLE;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_hs_s) begin
                  bvalid_q <= 1'b1;
                  wstate_q <= W_RESP;
                  if (wr_ok_s) begin
                     bresp_q <= RESP_OKAY;
                  end else begin
                     bresp_q <= RESP_SLVERR;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= W_IDLE;
               end
            end
            default: begin
               bvalid_q <= 1'b0;
               wstate_q <= W_IDLE;
            end
         endcase
      end
   end

   // Register bank: accepted writes to RW indices land on the handshake edge.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < REG_NUM; k++) begin
            regs_q[k] <= RESET_VAL;
         end
      end else if (aw_hs_s && wr_ok_s) begin
         regs_q[addr_idx(awaddr)] <= wdata;
      end
   end

   // Read FSM: arready re-arms in idle, response held until accepted.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= 32'h0000_0000;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_hs_s) begin
                  rdata_q   <= rd_data_s;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rstate_q  <= R_RESP;
                  if (rd_ok_s) begin
                     rresp_q <= RESP_OKAY;
                  end else begin
                     rresp_q <= RESP_SLVERR;
                  end
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rstate_q  <= R_IDLE;
               end
            end
            default: begin
               rvalid_q  <= 1'b0;
               arready_q <= 1'b0;
               rstate_q  <= R_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < REG_NUM; g++) begin : g_regs_out
      assign regs_o[32*g +: 32] = regs_q[g];
   end

   assign awready = aw_hs_s;
   assign wready  = aw_hs_s;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Bench for vga_axil_regfile: expected responses queued at issue, checked
// against the AXI-Lite response channels as they complete.

module tb_vga_axil_regfile;
   import vga_axil_pkg::*;

   localparam int N = 8;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   logic              clk = 1'b0;
   logic              arst_n;
   axil_addr_t        awaddr, araddr;
   axil_data_t        wdata, rdata;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   axil_resp_e        bresp, rresp;
   logic [31:0]       status_i;
   logic [N*32-1:0]   regs_o;

   int                err_cnt = 0;
   int                chk_cnt = 0;
   logic [31:0]       exp_regs [N];
   logic [1:0]        bq [$];
   rexp_t             rq [$];

   vga_axil_regfile dut (
      .clk(clk), .arst_n(arst_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .status_i(status_i), .regs_o(regs_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'h0000_0020);
   endfunction

   // Model write: returns expected bresp, updates model on success.
   function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d);
      logic [2:0] idx;
      idx = a[4:2];
      if (addr_ok(a) && idx != 3'd7) begin
         exp_regs[idx] = d;
         return 2'b00;
      end
      return 2'b10;
   endfunction

   function automatic rexp_t model_read(input logic [31:0] a);
      rexp_t e;
      logic [2:0] idx;
      idx = a[4:2];
      if (!addr_ok(a)) begin
         e.d = 32'h0; e.r = 2'b10;
      end else if (idx == 3'd7) begin
         e.d = status_i; e.r = 2'b00;
      end else begin
         e.d = exp_regs[idx]; e.r = 2'b00;
      end
      return e;
   endfunction

   task automatic check_regs(input string tag);
      for (int k = 0; k < N; k++) begin
         check_eq(tag, {32'h0, regs_o[32*k +: 32]}, {32'h0, exp_regs[k]});
      end
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
      int n;
      bq.push_back(model_write(a, d));
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!awready && n < 50);
      check_eq("aw_accept", {63'h0, awready & wready}, 64'h1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a);
      int n;
      rq.push_back(model_read(a));
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!arready && n < 50);
      check_eq("ar_accept", {63'h0, arready}, 64'h1);
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((bq.size() + rq.size()) != 0 && n < 50) begin
         @(posedge clk); n++;
      end
      #1;
      check_eq("drain", 64'(bq.size() + rq.size()), 64'h0);
   endtask

   // Response monitor: one pop per completed handshake, sampled mid-cycle.
   always @(negedge clk) begin
      if (arst_n && bvalid && bready) begin
         if (bq.size() == 0) begin
            check_eq("b_unexpected", 64'h1, 64'h0);
         end else begin
            check_eq("bresp", {62'h0, bresp}, {62'h0, bq.pop_front()});
         end
      end
      if (arst_n && rvalid && rready) begin
         if (rq.size() == 0) begin
            check_eq("r_unexpected", 64'h1, 64'h0);
         end else begin
            rexp_t e;
            e = rq.pop_front();
            check_eq("rresp", {62'h0, rresp}, {62'h0, e.r});
            check_eq("rdata", {32'h0, rdata}, {32'h0, e.d});
         end
      end
   end

   initial begin
      logic [31:0] rnd;
      rexp_t       e;
      arst_n = 1'b0;
      awaddr = 32'h0; wdata = 32'h0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      araddr = 32'h0; arvalid = 1'b0; rready = 1'b1; status_i = 32'h0;
      for (int k = 0; k < N; k++) exp_regs[k] = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_awready", {63'h0, awready}, 64'h0);
      check_eq("rst_bvalid", {63'h0, bvalid}, 64'h0);
      check_eq("rst_bresp", {62'h0, bresp}, 64'h0);
      check_eq("rst_arready", {63'h0, arready}, 64'h0);
      check_eq("rst_rvalid", {63'h0, rvalid}, 64'h0);
      check_eq("rst_rresp", {62'h0, rresp}, 64'h0);
      check_eq("rst_rdata", {32'h0, rdata}, 64'h0);
      check_regs("rst_regs");
      @(posedge clk); #1; arst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check_eq("arready_after_rst", {63'h0, arready}, 64'h1);
      @(posedge clk); #1;

      // 1: basic write/read
      axi_write(32'h4, 32'h0000_0004);
      check_eq("regs_o_1", {32'h0, regs_o[63:32]}, 64'h4);
      axi_read(32'h4);
      for (int k = 0; k < 7; k++) begin
         rnd = $urandom;
         axi_write(32'(k * 4), rnd);
      end
      for (int k = 0; k < 7; k++) axi_read(32'(k * 4));
      drain();
      check_regs("regs_pattern");

      // 2: illegal addresses
      axi_write(32'h3, 32'hDEAD_BEEF);
      axi_write(32'h20, 32'hDEAD_BEEF);
      axi_read(32'h3);
      axi_read(32'h20);
      drain();
      check_regs("regs_illegal");

      // 3: status register
      status_i = 32'h1234_5678;
      axi_read(32'h1C);
      axi_write(32'h1C, 32'hFFFF_0000);
      axi_read(32'h1C);
      drain();
      check_regs("regs_status");

      // 4: write response backpressure with a second write pending
      bready = 1'b0;
      axi_write(32'hC, 32'h0BAD_F00D);
      bq.push_back(model_write(32'h10, 32'h5555_0000));
      awaddr = 32'h10; wdata = 32'h5555_0000; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_bvalid", {63'h0, bvalid}, 64'h1);
         check_eq("bp_bresp", {62'h0, bresp}, 64'h0);
         check_eq("bp_awready", {63'h0, awready}, 64'h0);
      end
      @(posedge clk); #1; bready = 1'b1;
      @(negedge clk);
      check_eq("bp_hs_awready", {63'h0, awready}, 64'h0);
      @(negedge clk);
      check_eq("bp_second_accept", {63'h0, awready}, 64'h1);
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
      drain();
      check_regs("regs_bp");

      // 5: same-cycle read and write to one index returns the old value
      axi_write(32'h8, 32'h0000_0000);
      drain();
      rq.push_back(model_read(32'h8));
      bq.push_back(model_write(32'h8, 32'hA5A5_A5A5));
      awaddr = 32'h8; wdata = 32'hA5A5_A5A5; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h8; arvalid = 1'b1;
      @(negedge clk);
      check_eq("same_awready", {63'h0, awready}, 64'h1);
      check_eq("same_arready", {63'h0, arready}, 64'h1);
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      drain();
      axi_read(32'h8);
      drain();

      // 6: reset with both responses pending
      bready = 1'b0; rready = 1'b0;
      axi_write(32'h4, 32'h0000_0077);
      axi_read(32'hC);
      @(negedge clk);
      check_eq("pend_bvalid", {63'h0, bvalid}, 64'h1);
      check_eq("pend_rvalid", {63'h0, rvalid}, 64'h1);
      @(posedge clk); #2; arst_n = 1'b0; #1;
      check_eq("mid_rst_bvalid", {63'h0, bvalid}, 64'h0);
      check_eq("mid_rst_rvalid", {63'h0, rvalid}, 64'h0);
      check_eq("mid_rst_arready", {63'h0, arready}, 64'h0);
      bq.delete(); rq.delete();
      for (int k = 0; k < N; k++) exp_regs[k] = 32'h0;
      check_regs("mid_rst_regs");
      @(posedge clk); #1; arst_n = 1'b1; bready = 1'b1; rready = 1'b1;
      axi_read(32'h4);
      drain();
      e = model_read(32'h4);
      check_eq("post_rst_model", {32'h0, e.d}, 64'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
